// File: rtl/gru_ctrl_pkg.sv
// Shared types for the GRU time-step sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package gru_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        CAPT,
        FIN
    } gru_ctrl_state_t;

    // Hold counter must be able to represent CELL_LATENCY itself, because it
    // increments once more on the cycle it leaves HOLD.
    function automatic int hold_cnt_w(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/gru_hold_timer.sv
// Clearable up-counter with a terminal-count flag, used to time the HOLD phase.
// Latency: tc is combinational from the count register; count updates on the next edge.
// Backpressure: none; counts whenever en is high.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clear       force the count to zero (takes priority over en)
//   en          increment the count
//   tc          count has reached LATENCY-1
module gru_hold_timer
    import gru_ctrl_pkg::*;
#(
    parameter int LATENCY = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = hold_cnt_w(LATENCY);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(LATENCY - 1));

endmodule

// File: rtl/gru_seq_ctrl.sv
// Time-step sequencer: feeds x_t and h_{t-1} to an unmodified gruCell and recycles h_t.
// Latency: 1 (LOAD) + CELL_LATENCY (HOLD) + 1 (CAPT) cycles per step, plus start and FIN cycles.
// Backpressure: x_ready is high in LOAD only; the sequencer waits there indefinitely for x_valid.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   start, seq_len       begin a sequence of seq_len steps (sampled in IDLE only)
//   x_valid/x_data/x_ready  input frame stream
//   cell_x_t, cell_h_prev   registered cell inputs, frozen while the cell computes
//   cell_h_t             cell result, captured after CELL_LATENCY cycles
//   busy, done, h_out    status, one-cycle completion pulse, final hidden state
//   step                 index of the time step in flight
module gru_seq_ctrl
    import gru_ctrl_pkg::*;
#(
    parameter int WIDTH        = 11,
    parameter int NFRAC        = 6,
    parameter int X_SIZE       = 6,
    parameter int H_SIZE       = 120,
    parameter int CELL_LATENCY = 18,
    parameter int SEQ_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SEQ_W-1:0]        seq_len,
    input  logic                    x_valid,
    input  logic signed [WIDTH-1:0] x_data      [X_SIZE],
    output logic                    x_ready,
    output logic signed [WIDTH-1:0] cell_x_t    [X_SIZE],
    output logic signed [WIDTH-1:0] cell_h_prev [H_SIZE],
    input  logic signed [WIDTH-1:0] cell_h_t    [H_SIZE],
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] h_out       [H_SIZE],
    output logic [SEQ_W-1:0]        step
);

    // NFRAC only describes the fixed-point format of the words passed through;
    // an empty block elaborates when the format is nonsensical, as a visible marker.
    if (NFRAC >= WIDTH) begin : g_nfrac_exceeds_width
    end

    gru_ctrl_state_t  state, state_nxt;
    logic [SEQ_W-1:0] seq_len_q;
    logic             hold_clr;
    logic             hold_en;
    logic             hold_tc;
    logic             last_step;

    assign last_step = (step == seq_len_q - SEQ_W'(1));

    gru_hold_timer #(
        .LATENCY (CELL_LATENCY)
    ) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .clear (hold_clr),
        .en    (hold_en),
        .tc    (hold_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_clr  = 1'b0;
        hold_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (seq_len == '0) ? FIN : LOAD;
                end
            end
            LOAD: begin
                if (x_valid) begin
                    hold_clr  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                hold_en = 1'b1;
                if (hold_tc) begin
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                state_nxt = last_step ? FIN : LOAD;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign x_ready = (state == LOAD);
    assign busy    = (state != IDLE);
    assign done    = (state == FIN);

    // h_out is loaded on the transition into FIN (with the value cell_h_prev
    // takes at that same edge) so that it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_len_q <= '0;
            step      <= '0;
            for (int i = 0; i < X_SIZE; i++) cell_x_t[i] <= '0;
            for (int i = 0; i < H_SIZE; i++) cell_h_prev[i] <= '0;
            for (int i = 0; i < H_SIZE; i++) h_out[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        seq_len_q <= seq_len;
                        step      <= '0;
                        for (int i = 0; i < H_SIZE; i++) cell_h_prev[i] <= '0;
                        if (seq_len == '0) begin
                            for (int i = 0; i < H_SIZE; i++) h_out[i] <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (x_valid) begin
                        cell_x_t <= x_data;
                    end
                end
                CAPT: begin
                    cell_h_prev <= cell_h_t;
                    if (last_step) begin
                        h_out <= cell_h_t;
                    end else begin
                        step <= step + SEQ_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gru_seq_ctrl.sv
module tb_gru_seq_ctrl;

    localparam int W      = 11;
    localparam int X      = 6;
    localparam int H      = 120;
    localparam int L      = 18;
    localparam int SW     = 8;
    localparam int BUDGET = 6000;
    localparam int STALL_STEP = 1;

    logic clk = 1'b0;
    logic reset, start, x_valid, x_ready, busy, done;
    logic [SW-1:0] seq_len, step;
    logic signed [W-1:0] x_data      [X];
    logic signed [W-1:0] cell_x_t    [X];
    logic signed [W-1:0] cell_h_prev [H];
    logic signed [W-1:0] cell_h_t    [H];
    logic signed [W-1:0] h_out       [H];

    int nchecks = 0;
    int nerrors = 0;

    // cell model: mode 0 -> constant h_t[i]=i; mode 1 -> h_t = h_prev + x[i%X] + i,
    // valid only once the inputs have been stable for L cycles (all-ones otherwise)
    int model_mode = 0;
    int mcnt = 0;
    logic signed [W-1:0] px [X];
    logic signed [W-1:0] ph [H];

    always #5 clk = ~clk;

    gru_seq_ctrl #(
        .WIDTH(W), .NFRAC(6), .X_SIZE(X), .H_SIZE(H), .CELL_LATENCY(L), .SEQ_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .seq_len(seq_len),
        .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
        .cell_x_t(cell_x_t), .cell_h_prev(cell_h_prev), .cell_h_t(cell_h_t),
        .busy(busy), .done(done), .h_out(h_out), .step(step)
    );

    always @(negedge clk) begin
        logic changed;
        changed = 1'b0;
        for (int i = 0; i < X; i++) if (cell_x_t[i] !== px[i]) changed = 1'b1;
        for (int i = 0; i < H; i++) if (cell_h_prev[i] !== ph[i]) changed = 1'b1;
        if (changed) mcnt <= 0;
        else if (mcnt < 1000) mcnt <= mcnt + 1;
        px <= cell_x_t;
        ph <= cell_h_prev;
    end

    always_comb begin
        for (int i = 0; i < H; i++) begin
            if (model_mode == 0) cell_h_t[i] = W'(i);
            else if (mcnt >= L) cell_h_t[i] = cell_h_prev[i] + cell_x_t[i % X] + W'(i);
            else cell_h_t[i] = '1;
        end
    end

    typedef struct {
        int n;        // seq_len
        int stall;    // cycles of x_valid low in LOAD of step STALL_STEP
        int base;     // frame generator seed
        int mode;     // cell model mode
        int glitch;   // cycle index of a spurious start (0 = none)
        int exp_lat;  // cycles from start cycle to done cycle
    } vec_t;

    vec_t vecs [6];

    function automatic logic signed [W-1:0] xval(input int base, input int s, input int j);
        return W'(base + s * 7 + j);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        int nz;
        chk({tag, "_x_ready"}, int'(x_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_step"}, int'(step), 0);
        nz = 0;
        for (int i = 0; i < X; i++) if (cell_x_t[i] !== '0) nz++;
        chk({tag, "_cell_x_t_nonzero_elems"}, nz, 0);
        nz = 0;
        for (int i = 0; i < H; i++) if (cell_h_prev[i] !== '0) nz++;
        chk({tag, "_cell_h_prev_nonzero_elems"}, nz, 0);
        nz = 0;
        for (int i = 0; i < H; i++) if (h_out[i] !== '0) nz++;
        chk({tag, "_h_out_nonzero_elems"}, nz, 0);
    endtask

    task automatic run_seq(input string tag, input vec_t v);
        int acc, stall_left, done_idx, ready_cyc, last_acc;
        int bad_space, bad_step, bad_busy, bad_wait, bad_h;
        int eh [H];
        model_mode = v.mode;
        acc = 0; stall_left = v.stall; done_idx = -1; ready_cyc = 0; last_acc = 0;
        bad_space = 0; bad_step = 0; bad_busy = 0; bad_wait = 0; bad_h = 0;
        @(negedge clk);
        start = 1'b1;
        seq_len = SW'(v.n);
        x_valid = 1'b1;
        for (int j = 0; j < X; j++) x_data[j] = 11'sh155;
        for (int idx = 1; idx <= BUDGET; idx++) begin
            @(negedge clk);
            start = (idx == v.glitch);
            if (v.glitch > 0 && idx >= v.glitch) seq_len = 8'd7;
            if (done) begin
                done_idx = idx;
                break;
            end
            if (!busy) bad_busy++;
            if (x_ready) begin
                ready_cyc++;
                if (acc == STALL_STEP && stall_left > 0) begin
                    x_valid = 1'b0;
                    stall_left--;
                    for (int j = 0; j < X; j++)
                        if (cell_x_t[j] !== xval(v.base, acc - 1, j)) bad_wait++;
                end else begin
                    if (int'(step) != acc) bad_step++;
                    if (v.stall == 0 && acc > 0 && idx != last_acc + L + 2) bad_space++;
                    last_acc = idx;
                    x_valid = 1'b1;
                    for (int j = 0; j < X; j++) x_data[j] = xval(v.base, acc, j);
                    acc++;
                end
            end else begin
                // frames offered outside LOAD must be ignored
                x_valid = 1'b1;
                for (int j = 0; j < X; j++) x_data[j] = 11'sh155;
            end
        end
        chk({tag, "_done_latency"}, done_idx, v.exp_lat);
        chk({tag, "_accepts"}, acc, v.n);
        chk({tag, "_x_ready_cycles"}, ready_cyc, v.n + v.stall);
        chk({tag, "_step_at_accept_errs"}, bad_step, 0);
        chk({tag, "_busy_low_errs"}, bad_busy, 0);
        if (v.stall == 0) chk({tag, "_accept_spacing_errs"}, bad_space, 0);
        else chk({tag, "_cell_x_t_changed_in_stall"}, bad_wait, 0);
        for (int i = 0; i < H; i++) eh[i] = 0;
        if (v.n > 0) begin
            if (v.mode == 0) begin
                for (int i = 0; i < H; i++) eh[i] = i;
            end else begin
                for (int s = 0; s < v.n; s++)
                    for (int i = 0; i < H; i++) eh[i] += int'(xval(v.base, s, i % X)) + i;
            end
        end
        for (int i = 0; i < H; i++) if (h_out[i] !== W'(eh[i])) bad_h++;
        chk({tag, "_h_out_bad_elems"}, bad_h, 0);
        start = 1'b0;
        x_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int waited, dn;
        vecs[0] = '{1,   0,  3, 0, 0, 21};    // single step, constant cell output
        vecs[1] = '{3,   0, 10, 1, 0, 61};    // three steps with latency-checked model
        vecs[2] = '{0,   0,  0, 1, 0, 1};     // empty sequence
        vecs[3] = '{2,   7, 20, 1, 0, 48};    // 7-cycle stall in step 1
        vecs[4] = '{2,   0, 30, 1, 5, 41};    // spurious start + seq_len change in HOLD
        vecs[5] = '{255, 0,  1, 1, 0, 5101};  // full-length sequence

        reset = 1'b1; start = 1'b0; seq_len = '0; x_valid = 1'b0;
        for (int j = 0; j < X; j++) x_data[j] = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_zero("after_reset");

        for (int k = 0; k < 6; k++) begin
            run_seq($sformatf("vec%0d", k), vecs[k]);
        end

        // reset during HOLD of step 2
        model_mode = 1;
        @(negedge clk);
        start = 1'b1; seq_len = 8'd3; x_valid = 1'b1;
        for (int j = 0; j < X; j++) x_data[j] = xval(40, 0, j);
        waited = 0; dn = 0;
        for (int idx = 1; idx <= 200; idx++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dn++;
            if (step == 8'd2 && !x_ready && busy) waited++;
            if (waited == 4) break;
        end
        chk("rst_reach_hold_step2", waited, 4);
        reset = 1'b1;
        @(negedge clk);
        check_idle_zero("rst_mid_hold");
        reset = 1'b0;
        x_valid = 1'b0;
        @(negedge clk);
        if (done) dn++;
        chk("rst_done_pulses", dn, 0);
        run_seq("after_rst", '{1, 0, 50, 1, 0, 21});

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
